ctu_cken_seq: RTL

Staggered cluster clock-enable sequencer in the CTU cmp_clk domain. On a start request it raises per-cluster clock enables one at a time, spaced by a programmable gap, to limit di/dt. On a stop request it lowers them in reverse order. Its outputs are the presynchronized enables and `start_clk_cl` consumed by the cmp_clk to cmp_gclk enable synchronizers.

---
 rtl/ctu_cken_pkg.sv | 20 ++
 rtl/ctu_cken_gap_cnt.sv | 31 +++
 rtl/ctu_cken_seq.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/ctu_cken_pkg.sv
// Shared constants for the CTU cluster clock-enable sequencer.
// State encoding, default sizing, and the sequencer FSM state type.
package ctu_cken_pkg;

    localparam int unsigned CKEN_NUM_DEFAULT   = 8;
    localparam int unsigned CKEN_GAP_W_DEFAULT = 4;

    localparam logic [1:0] ST_IDLE      = 2'b00;
    localparam logic [1:0] ST_RAMP_UP   = 2'b01;
    localparam logic [1:0] ST_ON        = 2'b10;
    localparam logic [1:0] ST_RAMP_DOWN = 2'b11;

    typedef enum logic [1:0] {
        StIdle     = ST_IDLE,
        StRampUp   = ST_RAMP_UP,
        StOn       = ST_ON,
        StRampDown = ST_RAMP_DOWN
    } cken_state_e;

endpackage

// File: rtl/ctu_cken_gap_cnt.sv
// Loadable down-counter timing the idle gap between enable steps.
// Holds at zero; load has priority over decrement.
module ctu_cken_gap_cnt
    import ctu_cken_pkg::*;
#(
    parameter int unsigned GAP_W = CKEN_GAP_W_DEFAULT
) (
    input  logic             clk,
    input  logic             rst_l,
    input  logic             load,
    input  logic [GAP_W-1:0] load_val,
    input  logic             dec,
    output logic             zero
);

    logic [GAP_W-1:0] cnt_q;

    // Gap count register: reload on a step, otherwise count down to zero.
    always_ff @(posedge clk) begin
        if (!rst_l) begin
            cnt_q <= '0;
        end else if (load) begin
            cnt_q <= load_val;
        end else if (dec && (cnt_q != '0)) begin
            cnt_q <= cnt_q - 1'b1;
        end
    end

    assign zero = (cnt_q == '0);

endmodule

// File: rtl/ctu_cken_seq.sv
// Staggered cluster clock-enable sequencer (cmp_clk domain).
// Ramps enables up one at a time on start, down in reverse order on stop,
// with a programmable gap between steps to limit di/dt.
// Optional macro CTU_CKEN_FORCE_EN adds the force_cken test override port.
module ctu_cken_seq
    import ctu_cken_pkg::*;
#(
    parameter int unsigned NUM_CKEN = CKEN_NUM_DEFAULT,
    parameter int unsigned GAP_W    = CKEN_GAP_W_DEFAULT
) (
    input  logic                cmp_clk,
    input  logic                rst_l,
    input  logic                start_req,
    input  logic                stop_req,
    input  logic [GAP_W-1:0]    gap_cyc,
    input  logic [NUM_CKEN-1:0] cken_mask,
`ifdef CTU_CKEN_FORCE_EN
    input  logic                force_cken,
`endif
    output logic [NUM_CKEN-1:0] cken_out,
    output logic                start_clk_cl,
    output logic                seq_busy,
    output logic                seq_done
);

    localparam int unsigned     IdxW    = (NUM_CKEN > 1) ? $clog2(NUM_CKEN) : 1;
    localparam logic [IdxW-1:0] LastIdx = IdxW'(NUM_CKEN - 1);

    cken_state_e         state_q;
    logic [IdxW-1:0]     idx_q;
    logic [IdxW-1:0]     idx_inc;
    logic [IdxW-1:0]     idx_dec;
    logic [GAP_W-1:0]    gap_q;
    logic [NUM_CKEN-1:0] mask_q;
    logic [NUM_CKEN-1:0] cken_q;
    logic                start_clk_q;
    logic                busy_q;
    logic                done_q;

    logic                go_up;
    logic                cnt_load;
    logic [GAP_W-1:0]    cnt_load_val;
    logic                cnt_dec;
    logic                cnt_zero;

    // Stop wins whenever both requests are present.
    assign go_up   = start_req & ~stop_req;
    assign idx_inc = idx_q + 1'b1;
    assign idx_dec = idx_q - 1'b1;

    // Gap counter control: fresh gap_cyc on accept/reversal, latched gap between steps.
    always_comb begin
        cnt_load     = 1'b0;
        cnt_load_val = gap_q;
        cnt_dec      = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (go_up) begin
                    cnt_load     = 1'b1;
                    cnt_load_val = gap_cyc;
                end
            end
            StRampUp: begin
                if (stop_req) begin
                    cnt_load     = 1'b1;
                    cnt_load_val = gap_cyc;
                end else if (!cnt_zero) begin
                    cnt_dec = 1'b1;
                end else if (idx_q != LastIdx) begin
                    cnt_load = 1'b1;
                end
            end
            StOn: begin
                if (stop_req) begin
                    cnt_load     = 1'b1;
                    cnt_load_val = gap_cyc;
                end
            end
            StRampDown: begin
                if (go_up) begin
                    cnt_load     = 1'b1;
                    cnt_load_val = gap_cyc;
                end else if (!cnt_zero) begin
                    cnt_dec = 1'b1;
                end else if (idx_q != '0) begin
                    cnt_load = 1'b1;
                end
            end
            default: begin
                cnt_load = 1'b0;
            end
        endcase
    end

    ctu_cken_gap_cnt #(
        .GAP_W (GAP_W)
    ) u_gap_cnt (
        .clk      (cmp_clk),
        .rst_l    (rst_l),
        .load     (cnt_load),
        .load_val (cnt_load_val),
        .dec      (cnt_dec),
        .zero     (cnt_zero)
    );

    // Sequencer FSM with registered enables and status outputs.
    always_ff @(posedge cmp_clk) begin
        if (!rst_l) begin
            state_q     <= StIdle;
            idx_q       <= '0;
            gap_q       <= '0;
            mask_q      <= '0;
            cken_q      <= '0;
            start_clk_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (go_up) begin
                        state_q   <= StRampUp;
                        gap_q     <= gap_cyc;
                        mask_q    <= cken_mask;
                        cken_q[0] <= cken_mask[0];
                        idx_q     <= '0;
                        busy_q    <= 1'b1;
                    end
                end
                StRampUp: begin
                    if (stop_req) begin
                        // Reverse in place: undo the bit just raised.
                        state_q       <= StRampDown;
                        gap_q         <= gap_cyc;
                        cken_q[idx_q] <= 1'b0;
                    end else if (cnt_zero) begin
                        if (idx_q == LastIdx) begin
                            state_q     <= StOn;
                            busy_q      <= 1'b0;
                            start_clk_q <= 1'b1;
                            done_q      <= 1'b1;
                        end else begin
                            // Masked clusters still take their step slot.
                            idx_q           <= idx_inc;
                            cken_q[idx_inc] <= mask_q[idx_inc];
                        end
                    end
                end
                StOn: begin
                    if (stop_req) begin
                        state_q         <= StRampDown;
                        gap_q           <= gap_cyc;
                        idx_q           <= LastIdx;
                        cken_q[LastIdx] <= 1'b0;
                        start_clk_q     <= 1'b0;
                        busy_q          <= 1'b1;
                    end
                end
                StRampDown: begin
                    if (go_up) begin
                        // Reverse in place: restore the bit just cleared.
                        state_q       <= StRampUp;
                        gap_q         <= gap_cyc;
                        cken_q[idx_q] <= mask_q[idx_q];
                    end else if (cnt_zero) begin
                        if (idx_q == '0) begin
                            state_q <= StIdle;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                        end else begin
                            idx_q           <= idx_dec;
                            cken_q[idx_dec] <= 1'b0;
                        end
                    end
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign seq_busy = busy_q;
    assign seq_done = done_q;

    // Force override bypasses the FSM and is the only combinational output term.
`ifdef CTU_CKEN_FORCE_EN
    assign cken_out     = cken_q | {NUM_CKEN{force_cken}};
    assign start_clk_cl = start_clk_q | force_cken;
`else
    assign cken_out     = cken_q;
    assign start_clk_cl = start_clk_q;
`endif

endmodule
